// File: rtl/fsm_seq_checker.sv
// Packet checker and word-order reversal stage: verifies the marker word and an
// incrementing sequence number per valid bus word, and forwards it word-reversed.
module fsm_seq_checker #(
  parameter int                    BUS_SIZE    = 16,
  parameter int                    WORD_SIZE   = 4,
  parameter logic [WORD_SIZE-1:0]  MARKER      = '1,
  parameter int                    CNT_W       = 8,
  parameter bit                    DROP_ON_ERR = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [BUS_SIZE-1:0] bus_data_in,
  output logic                valid_out,
  output logic [BUS_SIZE-1:0] bus_data_out,
  output logic [2:0]          state,
  output logic [2:0]          nxt_state,
  output logic                error,
  output logic                nxt_error,
  output logic [CNT_W-1:0]    err_count
);

  localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    FIRST_PKT = 3'd1,
    REG_PKT   = 3'd2,
    F_ERR     = 3'd3,
    SEQ_ERR   = 3'd4
  } state_t;

  localparam logic [WORD_SIZE-1:0] WORD_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Valid-only stream, no backpressure: a word is consumed on every edge where
  // valid_in is high, and valid_out marks each registered output word for one cycle.

  state_t                cur_q, nxt;
  logic [WORD_SIZE-1:0]  exp_q, exp_nxt;
  logic                  fail;
  logic                  load_out;
  logic [WORD_SIZE-1:0]  mk, sq;
  logic [BUS_SIZE-1:0]   rev_data;

  assign mk = bus_data_in[WORD_SIZE-1:0];
  assign sq = bus_data_in[BUS_SIZE-1 -: WORD_SIZE];

  always_comb begin
    rev_data = '0;
    for (int k = 0; k < WORD_NUM; k++) begin
      rev_data[(WORD_NUM-1-k)*WORD_SIZE +: WORD_SIZE] = bus_data_in[k*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_comb begin
    nxt     = cur_q;
    exp_nxt = exp_q;
    fail    = 1'b0;
    case (cur_q)
      RESET: nxt = FIRST_PKT;
      FIRST_PKT, F_ERR, SEQ_ERR: begin
        // First packet and resync packets re-seed the sequence without checking it.
        if (valid_in) begin
          if (mk == MARKER) begin
            nxt     = REG_PKT;
            exp_nxt = sq + WORD_ONE;
          end else begin
            nxt  = F_ERR;
            fail = 1'b1;
          end
        end
      end
      REG_PKT: begin
        if (valid_in) begin
          if (mk != MARKER) begin
            nxt  = F_ERR;
            fail = 1'b1;
          end else if (sq != exp_q) begin
            nxt  = SEQ_ERR;
            fail = 1'b1;
          end else begin
            exp_nxt = exp_q + WORD_ONE;
          end
        end
      end
      default: nxt = RESET;
    endcase
  end

  assign state     = cur_q;
  assign nxt_state = nxt;
  assign nxt_error = (nxt == F_ERR) || (nxt == SEQ_ERR);
  assign load_out  = valid_in && !(DROP_ON_ERR && fail);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_q        <= RESET;
      exp_q        <= '0;
      error        <= 1'b0;
      err_count    <= '0;
      valid_out    <= 1'b0;
      bus_data_out <= '0;
    end else begin
      cur_q     <= nxt;
      exp_q     <= exp_nxt;
      error     <= nxt_error;
      valid_out <= load_out;
      if (load_out) bus_data_out <= rev_data;
      if (fail && (err_count != '1)) err_count <= err_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Directed vector bench for fsm_seq_checker: one default instance and one with
// DROP_ON_ERR=1 and a 2-bit error counter, both driven by the same stimulus.
module tb_fsm_seq_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] bus_data_in = '0;

  logic        valid_out_a, error_a, nxt_error_a;
  logic [15:0] bus_data_out_a;
  logic [2:0]  state_a, nxt_state_a;
  logic [7:0]  err_count_a;

  logic        valid_out_d, error_d, nxt_error_d;
  logic [15:0] bus_data_out_d;
  logic [2:0]  state_d, nxt_state_d;
  logic [1:0]  err_count_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fsm_seq_checker dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in), .bus_data_in(bus_data_in),
    .valid_out(valid_out_a), .bus_data_out(bus_data_out_a), .state(state_a),
    .nxt_state(nxt_state_a), .error(error_a), .nxt_error(nxt_error_a),
    .err_count(err_count_a)
  );

  fsm_seq_checker #(.CNT_W(2), .DROP_ON_ERR(1'b1)) dut_d (
    .clk(clk), .reset(reset), .valid_in(valid_in), .bus_data_in(bus_data_in),
    .valid_out(valid_out_d), .bus_data_out(bus_data_out_d), .state(state_d),
    .nxt_state(nxt_state_d), .error(error_d), .nxt_error(nxt_error_d),
    .err_count(err_count_d)
  );

  typedef struct {
    logic        rst;
    logic        vin;
    logic [15:0] din;
    logic        chk_nxt;
    logic [2:0]  nxt;
    logic [2:0]  st;
    logic        vo;
    logic [15:0] dout;
    int          cnt;
    logic        vod;
    logic [15:0] dod;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic vin, input logic [15:0] din,
                     input logic chk_nxt, input logic [2:0] nxt, input logic [2:0] st,
                     input logic vo, input logic [15:0] dout, input int cnt,
                     input logic vod, input logic [15:0] dod);
    vec_t v;
    v.rst = rst; v.vin = vin; v.din = din; v.chk_nxt = chk_nxt; v.nxt = nxt;
    v.st = st; v.vo = vo; v.dout = dout; v.cnt = cnt; v.vod = vod; v.dod = dod;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [3:0]  sq;
    logic [15:0] wd, wo;
    logic        exp_err;
    int          cnt_sat;

    // reset held low for three cycles
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0, 0, 3'd0, 3'd0, 0, 16'h0, 0, 0, 16'h0);
    add(1, 0, 16'h0,    1, 3'd1, 3'd1, 0, 16'h0,    0, 0, 16'h0);
    add(1, 1, 16'h0ABF, 1, 3'd2, 3'd2, 1, 16'hFBA0, 0, 1, 16'hFBA0);
    add(1, 1, 16'h1ABF, 1, 3'd2, 3'd2, 1, 16'hFBA1, 0, 1, 16'hFBA1);
    add(1, 1, 16'h2ABF, 1, 3'd2, 3'd2, 1, 16'hFBA2, 0, 1, 16'hFBA2);
    add(1, 0, 16'h2ABF, 1, 3'd2, 3'd2, 0, 16'hFBA2, 0, 0, 16'hFBA2);
    // expected=3, sequence 5 -> SEQ_ERR; then resync on 9
    add(1, 1, 16'h5ABF, 1, 3'd4, 3'd4, 1, 16'hFBA5, 1, 0, 16'hFBA2);
    add(1, 1, 16'h9ABF, 1, 3'd2, 3'd2, 1, 16'hFBA9, 1, 1, 16'hFBA9);
    // sequence A..F then wrap to 0
    for (int i = 0; i < 7; i++) begin
      sq = 4'(10 + i);
      wd = {sq, 12'hABF};
      wo = {12'hFBA, sq};
      add(1, 1, wd, 1, 3'd2, 3'd2, 1, wo, 1, 1, wo);
    end
    // bad marker wins over bad sequence; F_ERR->F_ERR keeps counting
    add(1, 1, 16'h3AB7, 1, 3'd3, 3'd3, 1, 16'h7BA3, 2, 0, 16'hFBA0);
    add(1, 1, 16'h1230, 1, 3'd3, 3'd3, 1, 16'h0321, 3, 0, 16'hFBA0);
    add(1, 1, 16'h4566, 1, 3'd3, 3'd3, 1, 16'h6654, 4, 0, 16'hFBA0);
    add(1, 1, 16'h7ABF, 1, 3'd2, 3'd2, 1, 16'hFBA7, 4, 1, 16'hFBA7);
    // reset mid-stream, then FIRST_PKT accepts any sequence number
    add(0, 1, 16'h8ABF, 0, 3'd0, 3'd0, 0, 16'h0,    0, 0, 16'h0);
    add(1, 0, 16'h8ABF, 1, 3'd1, 3'd1, 0, 16'h0,    0, 0, 16'h0);
    add(1, 1, 16'h5ABF, 1, 3'd2, 3'd2, 1, 16'hFBA5, 0, 1, 16'hFBA5);
    add(1, 1, 16'h6ABF, 1, 3'd2, 3'd2, 1, 16'hFBA6, 0, 1, 16'hFBA6);
    add(1, 1, 16'h6ABF, 1, 3'd4, 3'd4, 1, 16'hFBA6, 1, 0, 16'hFBA6);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      valid_in    = vecs[i].vin;
      bus_data_in = vecs[i].din;
      #1;
      if (vecs[i].chk_nxt) begin
        exp_err = (vecs[i].nxt == 3'd3) || (vecs[i].nxt == 3'd4);
        check("nxt_state", i, 32'(nxt_state_a), 32'(vecs[i].nxt));
        check("nxt_error", i, 32'(nxt_error_a), 32'(exp_err));
        check("nxt_state_drop", i, 32'(nxt_state_d), 32'(vecs[i].nxt));
      end
      @(posedge clk);
      #1;
      exp_err = (vecs[i].st == 3'd3) || (vecs[i].st == 3'd4);
      cnt_sat = (vecs[i].cnt > 3) ? 3 : vecs[i].cnt;
      check("state", i, 32'(state_a), 32'(vecs[i].st));
      check("error", i, 32'(error_a), 32'(exp_err));
      check("valid_out", i, 32'(valid_out_a), 32'(vecs[i].vo));
      check("bus_data_out", i, 32'(bus_data_out_a), 32'(vecs[i].dout));
      check("err_count", i, 32'(err_count_a), 32'(vecs[i].cnt));
      check("state_drop", i, 32'(state_d), 32'(vecs[i].st));
      check("error_drop", i, 32'(error_d), 32'(exp_err));
      check("valid_out_drop", i, 32'(valid_out_d), 32'(vecs[i].vod));
      check("bus_data_out_drop", i, 32'(bus_data_out_d), 32'(vecs[i].dod));
      check("err_count_drop", i, 32'(err_count_d), 32'(cnt_sat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
